fifo_delay_reader: RTL and testbench

- Read-side controller for `fifo_with_delay`. It issues `read_en` to the FIFO and tracks reads in flight through the FIFO's `PIPELINE_DEPTH` output delay.
- It captures `data_out` when it arrives and presents it on a valid/ready stream with a skid buffer.
- It turns a fixed-latency, no-backpressure FIFO read port into a backpressurable stream for downstream consumers in the same top.

---
 rtl/fifo_delay_reader.sv | 94 +++++++++
 tb/tb_fifo_delay_reader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_delay_reader.sv
// Read-side controller for a fixed-latency FIFO: issues reads against buffer
// credit, tracks them through the read pipeline and re-emits them as a valid/ready stream.
module fifo_delay_reader #(
  parameter int DATA_WIDTH     = 8,
  parameter int PIPELINE_DEPTH = 4,
  parameter int BUF_DEPTH      = 6,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic                                fifo_empty,
  input  logic [DATA_WIDTH-1:0]               fifo_data,
  output logic                                fifo_read_en,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [DATA_WIDTH-1:0]               m_data,
  output logic [$clog2(PIPELINE_DEPTH+1)-1:0] in_flight,
  output logic                                idle,
  output logic [CNT_WIDTH-1:0]                words_out
);

  localparam int IFW = $clog2(PIPELINE_DEPTH+1);
  localparam int OCW = $clog2(BUF_DEPTH+1);
  localparam int PW  = $clog2(BUF_DEPTH);
  localparam int SW  = ((IFW > OCW) ? IFW : OCW) + 1;

  logic [PIPELINE_DEPTH-1:0] pend_q, pend_d;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCW-1:0]            occ_q, occ_d;
  logic [CNT_WIDTH-1:0]      words_q, words_d;
  logic [DATA_WIDTH-1:0]     mem [BUF_DEPTH];
  logic                      push, pop, credit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < PIPELINE_DEPTH; i++) in_flight = in_flight + IFW'(pend_q[i]);
  end

  // Credit counts words still in the read pipe plus words buffered; a same-cycle
  // pop is deliberately ignored so the issue path stays free of m_ready.
  assign credit       = (SW'(in_flight) + SW'(occ_q)) < SW'(BUF_DEPTH);
  assign fifo_read_en = rst_n && enable && !fifo_empty && credit;

  assign push      = pend_q[PIPELINE_DEPTH-1];
  assign m_valid   = (occ_q != '0);
  assign pop       = m_valid && m_ready;
  assign m_data    = m_valid ? mem[rd_ptr_q] : '0;
  assign idle      = (pend_q == '0) && (occ_q == '0);
  assign words_out = words_q;

  generate
    if (PIPELINE_DEPTH == 1) begin : g_pend1
      assign pend_d = fifo_read_en;
    end else begin : g_pendn
      assign pend_d = {pend_q[PIPELINE_DEPTH-2:0], fifo_read_en};
    end
  endgenerate

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    occ_d    = occ_q;
    if (push && !pop)      occ_d = occ_q + OCW'(1);
    else if (pop && !push) occ_d = occ_q - OCW'(1);
    words_d  = pop ? words_q + CNT_WIDTH'(1) : words_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      words_q  <= '0;
    end else begin
      pend_q   <= pend_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      words_q  <= words_d;
    end
  end

  // Storage needs no reset: m_data is masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= fifo_data;
  end

endmodule

// File: tb/tb_fifo_delay_reader.sv
// Bench for fifo_delay_reader: two instances (6-entry/16-bit counter and
// 3-entry/4-bit counter) fed by queue-based FIFO models and a transaction-level reference.
module tb_fifo_delay_reader;
  localparam int DW = 8;
  localparam int P  = 4;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, m_ready = 1'b0;
  logic [1:0]         fifo_empty = 2'b11;
  logic [1:0]         rd_en, m_valid, idle;
  logic [1:0][DW-1:0] fifo_data = {8'hEE, 8'hEE};
  logic [1:0][DW-1:0] m_data;
  logic [1:0][2:0]    in_flight;
  logic [15:0]        words0;
  logic [3:0]         words1;

  int ncmp = 0, nfail = 0;

  fifo_delay_reader #(.DATA_WIDTH(DW), .PIPELINE_DEPTH(P), .BUF_DEPTH(6), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty[0]),
    .fifo_data(fifo_data[0]), .fifo_read_en(rd_en[0]), .m_valid(m_valid[0]),
    .m_ready(m_ready), .m_data(m_data[0]), .in_flight(in_flight[0]),
    .idle(idle[0]), .words_out(words0));

  fifo_delay_reader #(.DATA_WIDTH(DW), .PIPELINE_DEPTH(P), .BUF_DEPTH(3), .CNT_WIDTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty[1]),
    .fifo_data(fifo_data[1]), .fifo_read_en(rd_en[1]), .m_valid(m_valid[1]),
    .m_ready(m_ready), .m_data(m_data[1]), .in_flight(in_flight[1]),
    .idle(idle[1]), .words_out(words1));

  always #5 clk = ~clk;

  // FIFO model: storage written by the stimulus, head/delay line owned by the driver
  logic [DW-1:0] fmem [2][1024];
  int            fhead [2] = '{0, 0};
  int            ftail [2] = '{0, 0};
  logic [DW-1:0] pipe  [2][P];
  logic [1:0]    rd_s = 2'b00;

  // Reference: words issued but not yet landed, and words buffered for output
  int            fl_t [2][64];
  logic [DW-1:0] fl_w [2][64];
  int            flh [2] = '{0, 0};
  int            flt [2] = '{0, 0};
  logic [DW-1:0] bq  [2][64];
  int            bh  [2] = '{0, 0};
  int            bt  [2] = '{0, 0};
  int            wcnt [2] = '{0, 0};
  int            mcyc = 0;

  function automatic int bd(input int k);
    return (k == 0) ? 6 : 3;
  endfunction

  function automatic logic [31:0] words_of(input int k);
    return (k == 0) ? {16'h0, words0} : {28'h0, words1};
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  task automatic push2(input logic [DW-1:0] w);
    for (int k = 0; k < 2; k++) begin
      fmem[k][ftail[k] % 1024] = w;
      ftail[k]++;
    end
  endtask

  always @(posedge clk) begin
    #2;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        fhead[k] = ftail[k];
        for (int i = 0; i < P; i++) pipe[k][i] = 8'hEE;
      end else begin
        for (int i = P-1; i > 0; i--) pipe[k][i] = pipe[k][i-1];
        if (rd_s[k] && fhead[k] != ftail[k]) begin
          pipe[k][0] = fmem[k][fhead[k] % 1024];
          fhead[k]++;
        end else begin
          pipe[k][0] = 8'hEE;
        end
      end
      fifo_data[k]  = pipe[k][P-1];
      fifo_empty[k] = (fhead[k] == ftail[k]);
    end
  end

  // Compare process: outputs checked mid-cycle, then the model advances across the next edge
  always @(negedge clk) begin
    int            infl, occ;
    logic          ere, emv;
    logic [DW-1:0] emd;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        chk("rst_read_en", k, rd_en[k], 0);
        chk("rst_m_valid", k, m_valid[k], 0);
        chk("rst_m_data", k, m_data[k], 0);
        chk("rst_in_flight", k, in_flight[k], 0);
        chk("rst_idle", k, idle[k], 1);
        chk("rst_words", k, words_of(k), 0);
        flh[k] = flt[k]; bh[k] = bt[k]; wcnt[k] = 0; rd_s[k] = 1'b0;
      end else begin
        infl = flt[k] - flh[k];
        occ  = bt[k] - bh[k];
        ere  = enable && !fifo_empty[k] && (infl + occ < bd(k));
        emv  = (occ > 0);
        emd  = emv ? bq[k][bh[k] % 64] : '0;
        chk("read_en", k, rd_en[k], ere);
        chk("m_valid", k, m_valid[k], emv);
        chk("m_data", k, m_data[k], emd);
        chk("in_flight", k, in_flight[k], infl);
        chk("idle", k, idle[k], (infl == 0) && (occ == 0));
        chk("words_out", k, words_of(k), (k == 0) ? (wcnt[k] & 32'hFFFF) : (wcnt[k] & 32'hF));
        if (emv && m_ready) begin bh[k]++; wcnt[k]++; end
        if (flt[k] != flh[k] && fl_t[k][flh[k] % 64] == mcyc) begin
          bq[k][bt[k] % 64] = fl_w[k][flh[k] % 64];
          bt[k]++; flh[k]++;
        end
        if (ere) begin
          fl_t[k][flt[k] % 64] = mcyc + P;
          fl_w[k][flt[k] % 64] = fmem[k][fhead[k] % 1024];
          flt[k]++;
        end
        rd_s[k] = rd_en[k];
      end
    end
    mcyc++;
  end

  initial begin
    logic [DW-1:0] t1 [4];
    int n_re, f_re, l_re, n_mv, f_mv, l_mv, hs;
    t1 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    #2;
    chk("lit_reset_idle", 0, idle[0], 1);
    chk("lit_reset_read_en", 0, rd_en[0], 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push2(t1[i]);

    // basic latency: reads cycles 0-3, words visible cycles 5-8
    @(posedge clk); #1 enable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("lit_t1_read_en", 0, rd_en[0], (c <= 3));
      chk("lit_t1_m_valid", 0, m_valid[0], (c >= 5 && c <= 8));
      if (c >= 5 && c <= 8) chk("lit_t1_m_data", 0, m_data[0], t1[c-5]);
    end
    chk("lit_t1_idle", 0, idle[0], 1);
    chk("lit_t1_words", 0, words0, 4);
    repeat (15) @(posedge clk);

    // backpressure: buffer fills to 6 and holds the first word
    #1 m_ready = 1'b0;
    for (int i = 0; i < 10; i++) push2(8'h10 + DW'(i));
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("lit_t2_m_valid", 0, m_valid[0], 1);
    chk("lit_t2_m_data", 0, m_data[0], 8'h10);
    chk("lit_t2_read_en", 0, rd_en[0], 0);
    chk("lit_t2_in_flight", 0, in_flight[0], 0);
    @(posedge clk); #1 m_ready = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("lit_t2_words", 0, words0, 14);

    // throughput: 30 back-to-back reads and 30 back-to-back words
    @(posedge clk); #1;
    for (int i = 0; i < 30; i++) push2(8'h80 + DW'(i));
    n_re = 0; f_re = -1; l_re = -1; n_mv = 0; f_mv = -1; l_mv = -1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (rd_en[0]) begin n_re++; if (f_re < 0) f_re = c; l_re = c; end
      if (m_valid[0]) begin n_mv++; if (f_mv < 0) f_mv = c; l_mv = c; end
    end
    chk("lit_t3_reads", 0, n_re, 30);
    chk("lit_t3_read_span", 0, l_re - f_re, 29);
    chk("lit_t3_first_read", 0, f_re, 0);
    chk("lit_t3_words", 0, n_mv, 30);
    chk("lit_t3_word_span", 0, l_mv - f_mv, 29);
    repeat (70) @(posedge clk);

    // empty FIFO with enable held high
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("lit_t4_empty_rd0", 0, rd_en[0], 0);
      chk("lit_t4_empty_rd1", 1, rd_en[1], 0);
    end

    // drop enable with three reads outstanding
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) push2(8'h30 + DW'(i));
    repeat (3) @(posedge clk);
    #1 enable = 1'b0;
    @(negedge clk);
    chk("lit_t4_in_flight", 0, in_flight[0], 3);
    hs = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      chk("lit_t4_no_issue", 0, rd_en[0], 0);
      if (m_valid[0] && m_ready) hs++;
    end
    chk("lit_t4_handshakes", 0, hs, 3);
    chk("lit_t4_idle", 0, idle[0], 1);
    chk("lit_t4_words", 0, words0, 47);

    // reset mid-operation with in_flight=2, occ=3
    @(posedge clk); #1 m_ready = 1'b0; enable = 1'b1;
    repeat (5) @(posedge clk);
    #1 enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 enable = 1'b1;
    #2;
    chk("lit_t5_pre_in_flight", 0, in_flight[0], 2);
    chk("lit_t5_pre_m_valid", 0, m_valid[0], 1);
    chk("lit_t5_pre_read_en", 0, rd_en[0], 1);
    rst_n = 1'b0;
    #1;
    chk("lit_t5_m_valid", 0, m_valid[0], 0);
    chk("lit_t5_read_en", 0, rd_en[0], 0);
    chk("lit_t5_in_flight", 0, in_flight[0], 0);
    chk("lit_t5_words", 0, words0, 0);
    chk("lit_t5_idle", 0, idle[0], 1);
    chk("lit_t5_words1", 1, words1, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 3; i++) push2(8'h50 + DW'(i));
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("lit_t5_post_words", 0, words0, 3);
    chk("lit_t5_post_words1", 1, words1, 3);

    // counter wrap on the 4-bit instance: 17 words total
    @(posedge clk); #1;
    for (int i = 0; i < 14; i++) push2(8'hC0 + DW'(i));
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("lit_t6_wrap", 1, words1, 1);
    chk("lit_t6_words0", 0, words0, 17);
    chk("lit_t6_idle", 1, idle[1], 1);

    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
